page_buffer_mem: RTL

- Downstream stage of the packet writer; consumes its write-request stream (slot, page, line, 4 data bytes).
- Buffers requests in a small FIFO, commits them one per cycle into a line-addressed page memory, and serves a 1-cycle-latency read port for the packet reader.
- Checks per-slot line sequencing and raises a sticky error flag on a violation.

---
 rtl/page_buffer_mem.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/page_buffer_mem.sv
// page_buffer_mem: write-request FIFO feeding a line-addressed page memory.
// Writes commit one per cycle, there is a 1-cycle read port, and per-slot
// line sequencing is checked with a sticky error flag.
// Optional feature macro: PAGE_BUFFER_PARITY_EN. It adds per-byte even
// parity storage and the io_parityError output.
module page_buffer_mem #(
   parameter int NUM_POOLS      = 2,
   parameter int PAGES_PER_POOL = 8,
   parameter int LINES_PER_PAGE = 16,
   parameter int NUM_SLOTS      = 2,
   parameter int FIFO_DEPTH     = 4,
   localparam int POOL_W = (NUM_POOLS > 1) ? $clog2(NUM_POOLS) : 1,
   localparam int PAGE_W = (PAGES_PER_POOL > 1) ? $clog2(PAGES_PER_POOL) : 1,
   localparam int LINE_W = (LINES_PER_PAGE > 1) ? $clog2(LINES_PER_PAGE) : 1,
   localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_writeReqIn_valid,
   output logic              io_writeReqIn_ready,
   input  logic [SLOT_W-1:0] io_writeReqIn_bits_slot,
   input  logic [POOL_W-1:0] io_writeReqIn_bits_page_pool,
   input  logic [PAGE_W-1:0] io_writeReqIn_bits_page_pageNum,
   input  logic [LINE_W-1:0] io_writeReqIn_bits_line,
   input  logic [7:0]        io_writeReqIn_bits_data_0,
   input  logic [7:0]        io_writeReqIn_bits_data_1,
   input  logic [7:0]        io_writeReqIn_bits_data_2,
   input  logic [7:0]        io_writeReqIn_bits_data_3,
   input  logic              io_readReq_valid,
   output logic              io_readReq_ready,
   input  logic [POOL_W-1:0] io_readReq_bits_pool,
   input  logic [PAGE_W-1:0] io_readReq_bits_pageNum,
   input  logic [LINE_W-1:0] io_readReq_bits_line,
   output logic              io_readResp_valid,
   output logic [7:0]        io_readResp_bits_data_0,
   output logic [7:0]        io_readResp_bits_data_1,
   output logic [7:0]        io_readResp_bits_data_2,
   output logic [7:0]        io_readResp_bits_data_3,
`ifdef PAGE_BUFFER_PARITY_EN
   output logic              io_parityError,
`endif
   output logic [15:0]       io_commitCount,
   output logic              io_error
);

   localparam int MEM_DEPTH = NUM_POOLS * PAGES_PER_POOL * LINES_PER_PAGE;
   localparam int ADDR_W    = $clog2(MEM_DEPTH);
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = PTR_W + 1;
`ifdef PAGE_BUFFER_PARITY_EN
   localparam int MEM_W     = 36;
`else
   localparam int MEM_W     = 32;
`endif

   typedef struct packed {
      logic [SLOT_W-1:0] slot;
      logic [POOL_W-1:0] pool;
      logic [PAGE_W-1:0] page;
      logic [LINE_W-1:0] line;
      logic [31:0]       data;
   } wr_entry_t;

   // Flat line address: pool-major, then page, then line.
   function automatic logic [ADDR_W-1:0] line_addr(input logic [POOL_W-1:0] pool,
                                                   input logic [PAGE_W-1:0] page,
                                                   input logic [LINE_W-1:0] line);
      int a;
      a = (int'(pool) * PAGES_PER_POOL + int'(page)) * LINES_PER_PAGE + int'(line);
      return a[ADDR_W-1:0];
   endfunction

`ifdef PAGE_BUFFER_PARITY_EN
   // Even parity per byte: the parity bit makes each 9-bit group hold an even number of ones.
   function automatic logic [3:0] byte_parity(input logic [31:0] d);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) begin
         p[i] = ^d[8*i +: 8];
      end
      return p;
   endfunction
`endif

   // FIFO state
   wr_entry_t         fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // Memory and read response
   logic [MEM_W-1:0]  mem_q [MEM_DEPTH];
   logic              resp_valid_q;
   logic [MEM_W-1:0]  resp_word_q;

   // Commit / sequence checker state
   logic [15:0]       commit_cnt_q;
   logic              error_q, error_d;
   logic              active_q    [NUM_SLOTS];
   logic [POOL_W-1:0] last_pool_q [NUM_SLOTS];
   logic [PAGE_W-1:0] last_page_q [NUM_SLOTS];
   logic [LINE_W-1:0] last_line_q [NUM_SLOTS];
   logic              active_d;

   // Control signals
   wr_entry_t         in_entry;
   wr_entry_t         head;
   logic              full;
   logic              push;
   logic              commit;
   logic              rd_fire;
   logic              seq_legal;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W-1:0] raddr;
   logic [MEM_W-1:0]  wword;

   assign in_entry.slot = io_writeReqIn_bits_slot;
   assign in_entry.pool = io_writeReqIn_bits_page_pool;
   assign in_entry.page = io_writeReqIn_bits_page_pageNum;
   assign in_entry.line = io_writeReqIn_bits_line;
   assign in_entry.data = {io_writeReqIn_bits_data_3, io_writeReqIn_bits_data_2,
                           io_writeReqIn_bits_data_1, io_writeReqIn_bits_data_0};

   assign head  = fifo_q[rd_ptr_q];
   assign waddr = line_addr(head.pool, head.page, head.line);
   assign raddr = line_addr(io_readReq_bits_pool, io_readReq_bits_pageNum, io_readReq_bits_line);

`ifdef PAGE_BUFFER_PARITY_EN
   assign wword = {byte_parity(head.data), head.data};
`else
   assign wword = head.data;
`endif

   // Arbitration: a full FIFO forces a drain; otherwise reads win, and the FIFO commits when idle.
   always_comb begin
      full                = (count_q == CNT_W'(FIFO_DEPTH));
      io_writeReqIn_ready = (count_q < CNT_W'(FIFO_DEPTH));
      io_readReq_ready    = !full;
      push                = io_writeReqIn_valid && io_writeReqIn_ready;
      rd_fire             = io_readReq_valid && !full;
      commit              = full || (!io_readReq_valid && (count_q != '0));
   end

   // FIFO pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (commit) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !commit) begin
         count_d = count_q + 1'b1;
      end else if (!push && commit) begin
         count_d = count_q - 1'b1;
      end
   end

   // FIFO control registers; in-flight entries are dropped by clearing the pointers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO payload storage (not reset).
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= in_entry;
      end
   end

   // Page memory write port (contents are not reset).
   always_ff @(posedge clock) begin
      if (commit) begin
         mem_q[waddr] <= wword;
      end
   end

   // Read port: the response appears the cycle after acceptance and its data holds until the next one.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         resp_valid_q <= 1'b0;
         resp_word_q  <= '0;
      end else begin
         resp_valid_q <= rd_fire;
         if (rd_fire) begin
            resp_word_q <= mem_q[raddr];
         end
      end
   end

   // Sequence check of the committing head against its slot's history.
   always_comb begin
      seq_legal = 1'b1;
      active_d  = active_q[head.slot];
      error_d   = error_q;
      if (head.line == '0) begin
         seq_legal = 1'b1;
         active_d  = 1'b1;
      end else begin
         seq_legal = active_q[head.slot]
                  && (head.pool == last_pool_q[head.slot])
                  && (head.page == last_page_q[head.slot])
                  && (head.line == LINE_W'(last_line_q[head.slot] + 1'b1));
      end
      if (head.line == LINE_W'(LINES_PER_PAGE - 1)) begin
         active_d = 1'b0;
      end
      if (commit && !seq_legal) begin
         error_d = 1'b1;
      end
   end

   // Per-slot history, sticky error and commit counter update on each commit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            active_q[s]    <= 1'b0;
            last_pool_q[s] <= '0;
            last_page_q[s] <= '0;
            last_line_q[s] <= '0;
         end
         error_q      <= 1'b0;
         commit_cnt_q <= '0;
      end else begin
         error_q <= error_d;
         if (commit) begin
            active_q[head.slot]    <= active_d;
            last_pool_q[head.slot] <= head.pool;
            last_page_q[head.slot] <= head.page;
            last_line_q[head.slot] <= head.line;
            commit_cnt_q           <= commit_cnt_q + 16'd1;
         end
      end
   end

   assign io_readResp_valid       = resp_valid_q;
   assign io_readResp_bits_data_0 = resp_word_q[7:0];
   assign io_readResp_bits_data_1 = resp_word_q[15:8];
   assign io_readResp_bits_data_2 = resp_word_q[23:16];
   assign io_readResp_bits_data_3 = resp_word_q[31:24];
   assign io_commitCount          = commit_cnt_q;
   assign io_error                = error_q;

`ifdef PAGE_BUFFER_PARITY_EN
   assign io_parityError = resp_valid_q && (resp_word_q[35:32] != byte_parity(resp_word_q[31:0]));
`endif

endmodule
